ifu: RTL and testbench

Instruction fetch unit for the npc core: owns the fetch PC, issues one-at-a-time read requests to instruction memory over a valid/ready channel and presents each fetched instruction, with its PC, to the decode stage through a valid/ready output. It replaces the current scheme where the instruction word is injected from the C testbench. Control-flow redirects (branch, jump, trap) from the execute stage restart fetch at a new address.

---
 rtl/ifu.sv | 108 ++++++++++
 tb/tb_ifu.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps at most one imem request in flight
// and hands each fetched word (or a fault marker) to decode over a valid/ready channel.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic        kill_reg;
  logic [31:0] inst_reg;
  logic [31:0] inst_pc_reg;
  logic        inst_fault_reg;

  logic req_fire;
  logic rsp_pending;
  logic kill_next;
  logic redirect_misaligned;

  assign req_fire            = (state_reg == REQ) && imem_req_ready;
  // A response is still owed to us after this edge if the request goes out now,
  // or if we are waiting and it has not arrived yet.
  assign rsp_pending         = req_fire || ((state_reg == WAIT) && !imem_rsp_valid);
  assign kill_next           = rsp_pending || (kill_reg && !imem_rsp_valid);
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      kill_reg       <= 1'b0;
      inst_reg       <= 32'h0;
      inst_pc_reg    <= 32'h0;
      inst_fault_reg <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= redirect_pc;
      kill_reg     <= kill_next;
      if (redirect_misaligned) begin
        // Never sent to memory; decode sees a faulting NOP and traps.
        state_reg      <= OUT;
        inst_reg       <= NOP_INST;
        inst_pc_reg    <= redirect_pc;
        inst_fault_reg <= 1'b1;
      end else begin
        state_reg <= rsp_pending ? WAIT : REQ;
      end
    end else begin
      // A stale response that shows up while not waiting retires the pending kill.
      if (kill_reg && imem_rsp_valid && (state_reg != WAIT)) begin
        kill_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: state_reg <= REQ;
        REQ: begin
          if (imem_req_ready) begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (kill_reg) begin
              kill_reg  <= 1'b0;
              state_reg <= REQ;
            end else begin
              inst_reg       <= imem_rsp_err ? NOP_INST : imem_rsp_data;
              inst_pc_reg    <= fetch_pc_reg;
              inst_fault_reg <= imem_rsp_err;
              state_reg      <= OUT;
            end
          end
        end
        OUT: begin
          if (inst_ready) begin
            fetch_pc_reg <= fetch_pc_reg + 32'd4;
            state_reg    <= REQ;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state_reg == REQ);
  assign imem_req_addr  = fetch_pc_reg;
  assign inst_valid     = (state_reg == OUT);
  assign inst           = inst_reg;
  assign inst_pc        = inst_pc_reg;
  assign inst_fault     = inst_fault_reg;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: table of fetch scenarios plus hand-written redirect
// and reset sequences, with a scoreboard of expected decode transfers.
module tb_ifu;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    int          k;
    logic [31:0] err_at;
    int          hold;
    logic        chk_gap;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_fault;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_hs = 0;
  int          gap = 0;
  int          mem_k;
  logic        mem_ready;
  logic [31:0] mem_err_addr;

  // Memory: accepts at most one request, answers k cycles later with data = address.
  initial begin : mem_model
    int          rsp_cnt;
    logic [31:0] rsp_addr;
    rsp_cnt = 0;
    rsp_addr = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = rsp_addr;
          imem_rsp_err   = (rsp_addr == mem_err_addr);
        end
      end
      imem_req_ready = mem_ready;
      if (imem_req_valid && imem_req_ready) begin
        rsp_cnt  = mem_k;
        rsp_addr = imem_req_addr;
        req_log.push_back(imem_req_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at negedge with inputs driven; samples after the memory model, then advances.
  task automatic next_cycle();
    exp_t e;
    #2;
    if (inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer actual pc=%h inst=%h required none", inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        $display("xfer pc=%h inst=%h fault=%0d cycle=%0d", inst_pc, inst, inst_fault, cyc);
        chk("xfer_pc", inst_pc, e.pc);
        chk("xfer_inst", inst, e.data);
        chk("xfer_fault", {31'b0, inst_fault}, {31'b0, e.fault});
      end
      gap = cyc - last_hs;
      last_hs = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      next_cycle();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!inst_valid && n < 80) begin
      next_cycle();
      n++;
    end
    checks++;
    if (!inst_valid) begin
      errors++;
      $display("FAIL %s_timeout actual inst_valid=0 required 1", name);
    end
  endtask

  task automatic chk_req_after(input string name, input int mark, input logic [31:0] addr);
    checks++;
    if (req_log.size() <= mark) begin
      errors++;
      $display("FAIL %s actual=no_request required=%h", name, addr);
    end else if (req_log[mark] !== addr) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, req_log[mark], addr);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] data, input logic fault);
    exp_t e;
    e.pc = pc;
    e.data = data;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  vec_t vecs[9];

  initial begin
    int mark;
    int bad_req;
    vecs[0] = '{1'b0, 32'h0,          1, 32'h1,          0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0,          1, 32'h1,          5, 1'b0, 32'h8000_0004, 32'h8000_0004, 1'b0};
    vecs[2] = '{1'b0, 32'h0,          1, 32'h1,          0, 1'b1, 32'h8000_0008, 32'h8000_0008, 1'b0};
    vecs[3] = '{1'b0, 32'h0,          1, 32'h8000_000C,  0, 1'b1, 32'h8000_000C, NOP,           1'b1};
    vecs[4] = '{1'b1, 32'h8000_0100,  2, 32'h1,          0, 1'b0, 32'h8000_0100, 32'h8000_0100, 1'b0};
    vecs[5] = '{1'b1, 32'h8000_0102,  1, 32'h1,          0, 1'b0, 32'h8000_0102, NOP,           1'b1};
    vecs[6] = '{1'b1, 32'hFFFF_FFFC,  1, 32'h1,          0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    vecs[7] = '{1'b0, 32'h0,          1, 32'h1,          0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[8] = '{1'b0, 32'h0,          3, 32'h1,          0, 1'b0, 32'h0000_0004, 32'h0000_0004, 1'b0};

    rst = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    mem_k = 1;
    mem_ready = 1'b0;
    mem_err_addr = 32'h1;
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_fault", {31'b0, inst_fault}, 32'h0);
    repeat (3) next_cycle();
    rst = 1'b0;
    chk("idle_req_valid", {31'b0, imem_req_valid}, 32'h0);
    next_cycle();
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    next_cycle();
    chk("stalled_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("stalled_req_addr", imem_req_addr, 32'h8000_0000);
    mem_ready = 1'b1;

    for (int i = 0; i < 9; i++) begin
      mem_k = vecs[i].k;
      mem_err_addr = vecs[i].err_at;
      push_exp(vecs[i].exp_pc, vecs[i].exp_inst, vecs[i].exp_fault);
      if (vecs[i].redir) begin
        redirect_valid = 1'b1;
        redirect_pc = vecs[i].rpc;
        next_cycle();
        redirect_valid = 1'b0;
      end
      if (vecs[i].hold > 0) begin
        inst_ready = 1'b0;
        wait_valid("hold_valid");
        for (int h = 0; h < vecs[i].hold; h++) begin
          chk("hold_inst_pc", inst_pc, vecs[i].exp_pc);
          chk("hold_inst", inst, vecs[i].exp_inst);
          chk("hold_no_req", {31'b0, imem_req_valid}, 32'h0);
          next_cycle();
        end
        inst_ready = 1'b1;
      end
      drain("vec");
      if (vecs[i].chk_gap) chk("xfer_gap", gap, 32'd3);
      if (vecs[i].hold > 0) begin
        chk("post_hold_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("post_hold_req_addr", imem_req_addr, vecs[i].exp_pc + 32'd4);
      end
    end
    bad_req = 0;
    foreach (req_log[j]) if (req_log[j] == 32'h8000_0102) bad_req++;
    chk("misaligned_not_fetched", bad_req, 32'd0);

    // Redirect while waiting on a slow response: it must be dropped.
    mem_k = 4;
    next_cycle();
    mem_k = 1;
    mark = req_log.size();
    push_exp(32'h8000_0100, 32'h8000_0100, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    next_cycle();
    redirect_valid = 1'b0;
    drain("wait_redirect");
    chk_req_after("wait_redirect_req", mark, 32'h8000_0100);

    // Redirect in OUT coinciding with inst_ready: no transfer, no +4 advance.
    inst_ready = 1'b0;
    wait_valid("out_valid");
    chk("out_held_pc", inst_pc, 32'h8000_0104);
    mark = req_log.size();
    push_exp(32'h8000_0200, 32'h8000_0200, 1'b0);
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    next_cycle();
    redirect_valid = 1'b0;
    drain("out_redirect");
    chk_req_after("out_redirect_req", mark, 32'h8000_0200);

    // Asynchronous reset while a slow request is outstanding.
    mem_k = 4;
    next_cycle();
    rst = 1'b1;
    mem_k = 1;
    #1;
    chk("async_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("async_inst_pc", inst_pc, 32'h0);
    chk("async_inst", inst, 32'h0);
    chk("async_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("async_req_addr", imem_req_addr, 32'h8000_0000);
    next_cycle();
    next_cycle();
    mark = req_log.size();
    push_exp(32'h8000_0000, 32'h8000_0000, 1'b0);
    rst = 1'b0;
    drain("after_reset");
    chk_req_after("after_reset_req", mark, 32'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
